// File: rtl/uart_tx_serializer_if.sv
// FIFO read-port bundle between the TX FIFO and the UART transmit serializer.
// master is the popping side (serializer), slave is the FIFO.
interface uart_tx_serializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte from the TX FIFO and shifts it out as
// start, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.master fifo,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 stop2,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IdxW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(BAUD_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StStart, StData, StParity, StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  rd_en;
  logic                  bit_end;

  // Pop is held off during reset so the FIFO never loses a byte to a dead frame.
  assign rd_en           = (state_q == StIdle) && !fifo.fifo_empty && !rst;
  assign fifo.fifo_rd_en = rd_en;
  assign busy            = (state_q != StIdle) || rd_en;
  assign tx              = tx_q;
  assign tx_done         = done_q;
  assign bit_end         = (cnt_q == CntMax);

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        tx_d  = 1'b1;
        if (rd_en) state_d = StLoad;
      end
      StLoad: begin
        shift_d   = fifo.fifo_data;
        par_en_d  = par_en;
        stop2_d   = stop2;
        par_bit_d = (^fifo.fifo_data) ^ par_odd;
        cnt_d     = '0;
        idx_d     = '0;
        tx_d      = 1'b0;
        state_d   = StStart;
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            idx_d = '0;
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        // idx_q counts completed stop bits when two are configured.
        if (bit_end) begin
          if (stop2_q && (idx_q == '0)) begin
            idx_d = IdxW'(1);
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: cycle-by-cycle comparison against
// a frame-level reference model fed by a queue-based FIFO model.
module tb_uart_tx_serializer;
  localparam int unsigned B = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  logic par_en, par_odd, stop2;
  logic tx, busy, tx_done;

  uart_tx_serializer_if #(.DATA_WIDTH(W)) fifo ();

  uart_tx_serializer #(.DATA_WIDTH(W), .BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo    (fifo),
    .par_en  (par_en),
    .par_odd (par_odd),
    .stop2   (stop2),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  string phase = "init";

  logic [W-1:0] fifo_q[$];
  logic [3:0]   exp_q[$];   // per-cycle {tx, busy, rd_en, tx_done}
  logic [W-1:0] cur_byte;
  bit load_pending = 0;
  bit done_next = 0;
  bit pop_pending = 0;
  int obs_busy, obs_pops, obs_done;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Whole frame as seen on the line, using settings present in the LOAD cycle.
  task automatic build_frame(input logic [W-1:0] d);
    int ones;
    logic pbit;
    ones = $countones(d);
    pbit = ((ones % 2) == 1) ^ par_odd;
    for (int i = 0; i < B; i++) exp_q.push_back(4'b0100);
    for (int b = 0; b < W; b++)
      for (int i = 0; i < B; i++) exp_q.push_back({d[b], 3'b100});
    if (par_en)
      for (int i = 0; i < B; i++) exp_q.push_back({pbit, 3'b100});
    for (int i = 0; i < B * (stop2 ? 2 : 1); i++) exp_q.push_back(4'b1100);
  endtask

  task automatic model_cycle(output logic [3:0] e);
    logic rd;
    if (load_pending) begin
      e = 4'b1100;
      load_pending = 0;
      build_frame(cur_byte);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (exp_q.size() == 0) done_next = 1;
    end else begin
      rd = !fifo.fifo_empty;
      e = {1'b1, rd, rd, done_next};
      done_next = 0;
      if (rd) begin
        load_pending = 1;
        cur_byte = fifo_q[0];
      end
    end
  endtask

  task automatic compare();
    logic [3:0] e;
    if (rst) e = 4'b1000;
    else model_cycle(e);
    check_eq("tx", tx, e[3]);
    check_eq("busy", busy, e[2]);
    check_eq("rd_en", fifo.fifo_rd_en, e[1]);
    check_eq("tx_done", tx_done, e[0]);
    if (busy) obs_busy++;
    if (fifo.fifo_rd_en) obs_pops++;
    if (tx_done) obs_done++;
  endtask

  // Sample mid-cycle, then advance the FIFO model past the next rising edge.
  task automatic step();
    @(negedge clk);
    compare();
    pop_pending = fifo.fifo_rd_en;
    @(posedge clk);
    #1;
    if (pop_pending && fifo_q.size() > 0) fifo.fifo_data = fifo_q.pop_front();
    pop_pending = 0;
    fifo.fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [W-1:0] d);
    fifo_q.push_back(d);
    fifo.fifo_empty = 1'b0;
  endtask

  function automatic bit model_idle();
    return (exp_q.size() == 0) && !load_pending && !done_next && (fifo_q.size() == 0);
  endfunction

  task automatic run_idle(input int max_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!model_idle() && n < max_cycles);
    check_eq("drain", model_idle(), 1);
  endtask

  task automatic clear_obs();
    obs_busy = 0;
    obs_pops = 0;
    obs_done = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    par_en = 1'b0;
    par_odd = 1'b0;
    stop2 = 1'b0;
    fifo.fifo_empty = 1'b1;
    fifo.fifo_data = '0;
    clear_obs();

    phase = "reset";
    step();
    push(8'h55);
    step();
    step();
    rst = 1'b0;

    phase = "t1";
    clear_obs();
    run_idle(200);
    check_eq("busy_cycles", obs_busy, 42);
    check_eq("pops", obs_pops, 1);
    check_eq("dones", obs_done, 1);

    phase = "t2_even";
    par_en = 1'b1;
    par_odd = 1'b0;
    push(8'h07);
    run_idle(200);
    phase = "t2_odd";
    par_odd = 1'b1;
    push(8'h07);
    run_idle(200);

    phase = "t3";
    par_en = 1'b0;
    stop2 = 1'b1;
    clear_obs();
    push(8'hA3);
    push(8'h3C);
    push(8'hFF);
    run_idle(500);
    check_eq("pops", obs_pops, 3);
    check_eq("dones", obs_done, 3);

    phase = "t4";
    stop2 = 1'b0;
    clear_obs();
    repeat (100) step();
    check_eq("pops", obs_pops, 0);
    check_eq("busy_cycles", obs_busy, 0);
    check_eq("dones", obs_done, 0);

    phase = "t5";
    push(8'hC6);
    push(8'h81);
    repeat (20) step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_tx", tx, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd_en", fifo.fifo_rd_en, 0);
    check_eq("rst_done", tx_done, 0);
    exp_q.delete();
    load_pending = 0;
    done_next = 0;
    step();
    step();
    rst = 1'b0;
    clear_obs();
    run_idle(200);
    check_eq("pops", obs_pops, 1);
    check_eq("dones", obs_done, 1);

    phase = "t6";
    par_en = 1'b0;
    stop2 = 1'b0;
    push(8'h5A);
    repeat (10) step();
    par_en = 1'b1;
    stop2 = 1'b1;
    push(8'h96);
    repeat (10) step();
    par_odd = 1'b1;
    run_idle(300);

    phase = "rand";
    for (int it = 0; it < 40; it++) begin
      par_en = 1'($urandom_range(0, 1));
      par_odd = 1'($urandom_range(0, 1));
      stop2 = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 3)) push(W'($urandom));
      for (int c = 0; c < int'($urandom_range(0, 60)); c++) begin
        if ($urandom_range(0, 15) == 0) par_en = ~par_en;
        if ($urandom_range(0, 15) == 0) stop2 = ~stop2;
        if ($urandom_range(0, 15) == 0) par_odd = ~par_odd;
        step();
      end
    end
    run_idle(10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
